// File: rtl/wshb_stream_sink_pkg.sv
// Shared definitions for the Wishbone stream sink: register address
// indices, the bus word type and a byte-select helper.
package stream_sink_pkg;

   localparam logic [1:0] ADR_LEVEL = 2'd0;
   localparam logic [1:0] ADR_FLAGS = 2'd1;
   localparam logic [1:0] ADR_ACC   = 2'd2;
   localparam logic [1:0] ADR_STALL = 2'd3;

   localparam logic [3:0] SEL_FULL  = 4'hF;

   typedef logic [31:0] word_t;

   // Only whole-word accesses are accepted by the sink.
   function automatic logic is_full_sel(input logic [3:0] sel);
      return (sel == SEL_FULL);
   endfunction

endpackage

// File: rtl/wshb_stream_sink_if.sv
// Wishbone B4 classic bus bundle between the initiator (hw_support) and
// the stream sink responder.
interface wshb_stream_sink_if;
   import stream_sink_pkg::*;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   word_t       dat_ms;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   word_t       dat_sm;
   logic        err;
   logic        rty;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  ack, dat_sm, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output ack, dat_sm, err, rty
   );

endinterface

// File: rtl/wshb_stream_sink_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a zero-latency head word.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] PTR_ONE = LVL_W'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [LVL_W-1:0] wr_ptr_r;
   logic [LVL_W-1:0] rd_ptr_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Storage write; contents are not reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
   end

   assign pop_data = mem_r[rd_ptr_r[AW-1:0]];
   assign full     = (wr_ptr_r[LVL_W-1] != rd_ptr_r[LVL_W-1]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty    = (wr_ptr_r == rd_ptr_r);
   assign level    = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/wshb_stream_sink.sv
// Wishbone B4 classic responder that pushes 32-bit writes into a FIFO
// drained through a valid/ready port; reads return FIFO status.
// Optional statistics counters are built when STREAM_SINK_STATS_EN is defined.
module wshb_stream_sink
   import stream_sink_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 32,
   parameter int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   wshb_stream_sink_if.slave wb,
   output word_t            out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic       ack_r;
   logic       err_r;
   word_t      dat_sm_r;
   logic       req_s;
   logic [1:0] adr_idx_s;
   logic       ack_nxt_s;
   logic       err_nxt_s;
   logic       push_s;
   logic       pop_s;
   logic       rd_en_s;
   word_t      rd_data_s;
   logic       unused_s;
`ifdef STREAM_SINK_STATS_EN
   logic       stall_s;
   logic       clr_s;
   word_t      acc_cnt_r;
   word_t      stall_cnt_r;
`endif

   assign req_s     = wb.cyc & wb.stb & ~ack_r & ~err_r;
   assign adr_idx_s = wb.adr[3:2];
   assign pop_s     = out_valid & out_ready;
   assign out_valid = ~empty;
   assign unused_s  = ^{wb.cti, wb.bte, wb.adr[31:4], wb.adr[1:0]};

   // Request decode; full is taken before any same-edge pop, so a write
   // held by full waits one extra cycle after the pop frees a slot.
   always_comb begin
      ack_nxt_s = 1'b0;
      err_nxt_s = 1'b0;
      push_s    = 1'b0;
      rd_en_s   = 1'b0;
`ifdef STREAM_SINK_STATS_EN
      stall_s   = 1'b0;
      clr_s     = 1'b0;
`endif
      if (req_s) begin
         if (!wb.we) begin
            ack_nxt_s = 1'b1;
            rd_en_s   = 1'b1;
         end else if (!is_full_sel(wb.sel)) begin
            err_nxt_s = 1'b1;
`ifdef STREAM_SINK_STATS_EN
         end else if (adr_idx_s == ADR_ACC) begin
            ack_nxt_s = 1'b1;
            clr_s     = 1'b1;
`endif
         end else if (!full) begin
            ack_nxt_s = 1'b1;
            push_s    = 1'b1;
         end else begin
            ack_nxt_s = 1'b0;
`ifdef STREAM_SINK_STATS_EN
            stall_s   = 1'b1;
`endif
         end
      end else begin
         ack_nxt_s = 1'b0;
      end
   end

   // Read data selection by register index.
   always_comb begin
      rd_data_s = '0;
      case (adr_idx_s)
         ADR_LEVEL: rd_data_s = word_t'(level);
         ADR_FLAGS: rd_data_s = {30'd0, full, empty};
`ifdef STREAM_SINK_STATS_EN
         ADR_ACC:   rd_data_s = acc_cnt_r;
         ADR_STALL: rd_data_s = stall_cnt_r;
`endif
         default:   rd_data_s = '0;
      endcase
   end

   // Registered responses; read data only changes on a read ack.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
         dat_sm_r <= '0;
      end else begin
         ack_r <= ack_nxt_s;
         err_r <= err_nxt_s;
         if (rd_en_s) dat_sm_r <= rd_data_s;
      end
   end

`ifdef STREAM_SINK_STATS_EN
   // Accepted-word and full-stall counters, cleared by a write to ADR_ACC.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         acc_cnt_r   <= '0;
         stall_cnt_r <= '0;
      end else if (clr_s) begin
         acc_cnt_r   <= '0;
         stall_cnt_r <= '0;
      end else begin
         if (push_s)  acc_cnt_r   <= acc_cnt_r + 32'd1;
         if (stall_s) stall_cnt_r <= stall_cnt_r + 32'd1;
      end
   end
`endif

   assign wb.ack    = ack_r;
   assign wb.err    = err_r;
   assign wb.dat_sm = dat_sm_r;
   assign wb.rty    = 1'b0;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .push      (push_s),
      .push_data (wb.dat_ms),
      .pop       (pop_s),
      .pop_data  (out_data),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_wshb_stream_sink.sv
// Directed bench for wshb_stream_sink with DEPTH=4.
module tb_wshb_stream_sink;
   import stream_sink_pkg::*;

   logic        sys_clk;
   logic        sys_rst;
   word_t       out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  level;
   logic        full;
   logic        empty;
   int          n_tests;
   int          n_fail;
   word_t       q[$];

   wshb_stream_sink_if wbi ();

   wshb_stream_sink #(.DEPTH(4), .DATA_W(32), .LVL_W(3)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .wb        (wbi),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we_i, input logic [31:0] adr_i, input logic [31:0] dat_i, input logic [3:0] sel_i);
      wbi.cyc    = 1'b1;
      wbi.stb    = 1'b1;
      wbi.we     = we_i;
      wbi.adr    = adr_i;
      wbi.dat_ms = dat_i;
      wbi.sel    = sel_i;
   endtask

   task automatic idle();
      wbi.cyc = 1'b0;
      wbi.stb = 1'b0;
      wbi.we  = 1'b0;
   endtask

   // One classic cycle; lat counts negedges until ack/err (bounded).
   task automatic wb_xfer(input logic we_i, input logic [31:0] adr_i, input logic [31:0] dat_i,
                          input logic [3:0] sel_i, output int lat, output logic a_o,
                          output logic e_o, output logic [31:0] r_o);
      @(negedge sys_clk);
      drive(we_i, adr_i, dat_i, sel_i);
      lat = 0; a_o = 1'b0; e_o = 1'b0; r_o = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         lat++;
         if (wbi.ack || wbi.err) begin
            a_o = wbi.ack; e_o = wbi.err; r_o = wbi.dat_sm;
            break;
         end
      end
      idle();
   endtask

   task automatic wr_chk(input string tag, input logic [31:0] adr, input logic [31:0] dat);
      int lat; logic a; logic e; logic [31:0] r;
      wb_xfer(1'b1, adr, dat, 4'hF, lat, a, e, r);
      chk({tag, "_ack"}, 32'(a), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      int lat; logic a; logic e; logic [31:0] r;
      wb_xfer(1'b0, adr, 32'd0, 4'hF, lat, a, e, r);
      chk({tag, "_ack"}, 32'(a), 32'd1);
      chk({tag, "_dat"}, r, exp);
   endtask

   initial begin
      int lat; logic a; logic e; logic [31:0] r;
      n_tests = 0; n_fail = 0;
      sys_rst = 1'b1; out_ready = 1'b0;
      idle(); wbi.adr = '0; wbi.dat_ms = '0; wbi.sel = 4'h0; wbi.cti = 3'd0; wbi.bte = 2'd0;

      // Reset state
      #12;
      chk("rst_ack",   32'(wbi.ack), 32'd0);
      chk("rst_err",   32'(wbi.err), 32'd0);
      chk("rst_rty",   32'(wbi.rty), 32'd0);
      chk("rst_dat",   wbi.dat_sm, 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full",  32'(full), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      @(negedge sys_clk); sys_rst = 1'b0;

      // Four writes A0..A3 fill the DEPTH=4 FIFO
      wr_chk("wA0", 32'h0, 32'hA0);
      wr_chk("wA1", 32'h0, 32'hA1);
      wr_chk("wA2", 32'h0, 32'hA2);
      wr_chk("wA3", 32'h0, 32'hA3);
      chk("fill_level", 32'(level), 32'd4);
      chk("fill_head",  out_data, 32'hA0);
      chk("fill_valid", 32'(out_valid), 32'd1);
      chk("fill_full",  32'(full), 32'd1);

      // Fifth write stalls; one pop frees a slot, ack follows a cycle later
      @(negedge sys_clk); drive(1'b1, 32'h0, 32'hA4, 4'hF);
      @(negedge sys_clk); chk("stall_ack1", 32'(wbi.ack), 32'd0);
      @(negedge sys_clk); chk("stall_ack2", 32'(wbi.ack), 32'd0);
      out_ready = 1'b1;
      @(negedge sys_clk); out_ready = 1'b0;
      chk("stall_ack3",  32'(wbi.ack), 32'd0);
      chk("stall_level", 32'(level), 32'd3);
      @(negedge sys_clk);
      chk("stall_ack4",   32'(wbi.ack), 32'd1);
      chk("stall_level4", 32'(level), 32'd4);
      idle();
`ifdef STREAM_SINK_STATS_EN
      rd_chk("stall_cnt", 32'hC, 32'd3);
`endif

      // Drain order A1..A4
      @(negedge sys_clk); out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data",  out_data, 32'hA1 + 32'(i));
         @(negedge sys_clk);
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);

      // Partial byte-select write returns err, no push
      wr_chk("wB0", 32'h0, 32'hB0);
      q.push_back(32'hB0);
      wb_xfer(1'b1, 32'h0, 32'hEE, 4'h3, lat, a, e, r);
      chk("sel_err",   32'(e), 32'd1);
      chk("sel_ack",   32'(a), 32'd0);
      chk("sel_lat",   32'(lat), 32'd1);
      chk("sel_level", 32'(level), 32'd1);
      @(negedge sys_clk);
      chk("sel_err_low", 32'(wbi.err), 32'd0);
      wr_chk("wB1", 32'h0, 32'hB1);
      q.push_back(32'hB1);

      // Level 2, ten push+pop edges; pointers wrap repeatedly
      for (int k = 0; k < 10; k++) begin
         @(negedge sys_clk);
         chk("pp_head", out_data, q[0]);
         drive(1'b1, 32'h0, 32'hC0 + 32'(k), 4'hF);
         out_ready = 1'b1;
         @(negedge sys_clk);
         out_ready = 1'b0;
         chk("pp_ack", 32'(wbi.ack), 32'd1);
         idle();
         void'(q.pop_front());
         q.push_back(32'hC0 + 32'(k));
         chk("pp_level", 32'(level), 32'd2);
      end
      chk("pp_head_end", out_data, q[0]);

      // Status reads
      wr_chk("wD0", 32'h0, 32'hD0);
      rd_chk("rd_level3", 32'h0, 32'd3);
      rd_chk("rd_flags3", 32'h4, 32'd0);
      repeat (3) @(negedge sys_clk);
      chk("dat_hold", wbi.dat_sm, 32'd0);
`ifdef STREAM_SINK_STATS_EN
      rd_chk("rd_acc", 32'h8, 32'd18);
`else
      rd_chk("rd_adr8", 32'h8, 32'd0);
      rd_chk("rd_adrC", 32'hC, 32'd0);
`endif
      @(negedge sys_clk); out_ready = 1'b1;
      repeat (3) @(negedge sys_clk);
      out_ready = 1'b0;
      rd_chk("rd_flags_empty", 32'h4, 32'd1);

      // Cycle dropped while stalled: request discarded
      wr_chk("wF0", 32'h0, 32'hF0);
      wr_chk("wF1", 32'h0, 32'hF1);
      wr_chk("wF2", 32'h0, 32'hF2);
      wr_chk("wF3", 32'h0, 32'hF3);
      @(negedge sys_clk); drive(1'b1, 32'h0, 32'hF4, 4'hF);
      repeat (2) @(negedge sys_clk);
      idle();
      out_ready = 1'b1;
      @(negedge sys_clk); out_ready = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("drop_level", 32'(level), 32'd3);
      chk("drop_head",  out_data, 32'hF1);
      wr_chk("wF5", 32'h0, 32'hF5);

      // Async reset during a stalled write with the FIFO full
      @(negedge sys_clk); drive(1'b1, 32'h0, 32'hF6, 4'hF);
      repeat (2) @(negedge sys_clk);
      chk("pre_rst_full", 32'(full), 32'd1);
      #2 sys_rst = 1'b1;
      #1;
      chk("arst_ack",   32'(wbi.ack), 32'd0);
      chk("arst_empty", 32'(empty), 32'd1);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_valid", 32'(out_valid), 32'd0);
      idle();
      @(negedge sys_clk); sys_rst = 1'b0;
      wr_chk("wG0", 32'h0, 32'h600D);
      chk("post_rst_level", 32'(level), 32'd1);
      chk("post_rst_head",  out_data, 32'h600D);

      // Reset cancels an ack already on the bus
      @(negedge sys_clk); @(negedge sys_clk); drive(1'b0, 32'h0, 32'd0, 4'hF);
      @(posedge sys_clk); #1;
      chk("inflight_ack", 32'(wbi.ack), 32'd1);
      sys_rst = 1'b1;
      #1;
      chk("cancel_ack", 32'(wbi.ack), 32'd0);
      idle();
      @(negedge sys_clk); sys_rst = 1'b0;
      chk("cancel_level", 32'(level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
